mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory stage of the five-stage in-order pipeline, between the execute stage and `wb_stage`. Holds one instruction and waits for the data-SRAM read response when execute issued a load. Extracts and sign/zero-extends the loaded byte, halfword or word, or merges it for unaligned loads. Produces the 70-bit `ms_to_ws_bus` and a forwarding/stall bus to decode.

## Interface
- `ES_TO_MS_BUS_WD`, 110: execute→memory bus width, shared header.
- `MS_TO_WS_BUS_WD`, 70: memory→writeback bus width, shared header.
- `MS_TO_DS_FWD_WD`, 39: forwarding bus width, shared header.
- `clk`  in  1  clock; reset reset, synchronous, active-high; clock clk.
- `reset`  in  1  synchronous, active-high.
- `ws_allowin`  in  1  writeback can accept this cycle.
- `ms_allowin`  out  1  this stage can accept from execute.
- `es_to_ms_valid`  in  1  execute presents a valid instruction.
- `es_to_ms_bus`  in  110  bit fields:
  - [109:78] rt_value; [77] mem_req (a read was issued); [76] res_from_mem; [75] load_sign.
  - [74:72] load_op: 000 byte, 001 half, 010 word, 011 LWL, 100 LWR.
  - [71:70] addr_lo; [69] gr_we; [68:64] dest; [63:32] alu_result; [31:0] pc.
- `ms_to_ws_valid`  out  1  instruction ready for writeback.
- `ms_to_ws_bus`  out  70  bit fields: [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc.
- `ms_to_ds_fwd_bus`  out  39  bit fields:
  - [38] fwd_valid = ms_valid && gr_we.
  - [37] fwd_blocked = res_from_mem && !ms_ready_go.
  - [36:32] dest; [31:0] final_result.
- `data_sram_data_ok`  in  1  read response valid, one pulse per issued request.
- `data_sram_rdata`  in  32  read data, valid with data_ok.

## Operation
- Registers:
  - `ms_valid` resets to 0.
  - `bus_r` has no reset.
  - `rdata_buf` (32 bits).
  - `rdata_buf_valid` resets to 0.
- `ms_ready_go = !mem_req || data_sram_data_ok || rdata_buf_valid`.
- `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`.
- `ms_to_ws_valid = ms_valid && ms_ready_go`.
- When `ms_allowin` is high, `ms_valid <= es_to_ms_valid`. `bus_r` loads only when `es_to_ms_valid && ms_allowin`.
- Response buffer:
  - If `data_ok` arrives while `ms_valid && mem_req` and `!ws_allowin`, capture `rdata` into `rdata_buf` and set `rdata_buf_valid`.
  - Clear `rdata_buf_valid` on the cycle the instruction leaves (`ms_to_ws_valid && ws_allowin`).
- Effective read data is `rdata_buf_valid ? rdata_buf : data_sram_rdata`.
- Load extraction, `shift = addr_lo*8`:
  - byte: `rdata[shift+7:shift]`.
  - half: `rdata[shift+15:shift]`; addr_lo ∈ {0,2} is guaranteed upstream.
  - word: `rdata`.
  - For byte and half, the sign bit is replicated when `load_sign=1`; otherwise zero-fill.
- `final_result = res_from_mem ? load_value : alu_result`. `gr_we`, `dest` and `pc` pass through unchanged.
- Contract: `data_ok` for a request never precedes the cycle after its es→ms transfer. Requests complete in order, and at most one is outstanding in this stage.
- A `data_ok` arriving while `!ms_valid || !mem_req` is a protocol error; the stage ignores it.

## Timing
- Non-load instruction: one-cycle latency; `ms_to_ws_valid` is high the cycle after transfer.
- Load: `ms_to_ws_valid` is asserted combinationally in the `data_ok` cycle. If `ws_allowin` is high, the instruction leaves that cycle.
- Buffered response: output stays stable from `rdata_buf` until accepted.
- Simultaneous leave and arrive: a new instruction is accepted the same cycle the old one leaves, giving back-to-back throughput of 1 per cycle.
- Reset mid-load clears `ms_valid` and `rdata_buf_valid`; a stale `data_ok` after reset is ignored.
- Outputs during reset: `ms_to_ws_valid=0`, fwd_valid=0, `ms_allowin=1`.

## Configuration
- `MS_UNALIGNED_LOAD_EN` defined: LWL/LWR merge with rt_value.
  - LWL, by addr_lo: 0 → {rdata[7:0], rt[23:0]}; 1 → {rdata[15:0], rt[15:0]}; 2 → {rdata[23:0], rt[7:0]}; 3 → rdata.
  - LWR, by addr_lo: 0 → rdata; 1 → {rt[31:24], rdata[31:8]}; 2 → {rt[31:16], rdata[31:16]}; 3 → {rt[31:8], rdata[31:24]}.
- Not defined: load_op 011/100 behave as word loads and rt_value is unused.

## Structure
- Shared header `mycpu.h`: the three bus widths, load_op encodings, and the bit offsets of every bus field.
- Sub-module `load_align`: combinational; inputs load_op, load_sign, addr_lo, rdata, rt_value; output load_value. Contains the `MS_UNALIGNED_LOAD_EN` logic.

## Test plan
- ALU op: alu_result=0x1234 and gr_we=1 → next cycle `ms_to_ws_valid=1`, bus={1,dest,0x1234,pc}.
- Signed byte load: LB, addr_lo=2, rdata=0x8899AABB, `data_ok` 3 cycles late → fwd_blocked=1 until `data_ok`; final_result=0xFFFFFF99.
- Unsigned half load: LHU, addr_lo=2, rdata=0x8899AABB → 0x00008899.
- Backpressure: `ws_allowin=0` during `data_ok` (rdata=0xCAFEF00D, LW) → buffered; result stays 0xCAFEF00D on later `data_ok` pulses with junk rdata until `ws_allowin=1`.
- Unaligned loads with macro on: LWL addr_lo=1, rdata=0x11223344, rt=0xAABBCCDD → 0x3344CCDD. LWR addr_lo=2 → 0xAABB1122.
- Reset during an outstanding load, then a stray `data_ok` → `ms_valid` stays 0 and nothing is emitted.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
//   Shared definitions for the memory stage: bus widths, load_op encodings
//   and the field layout of the execute->memory, memory->writeback and
//   memory->decode forwarding buses (bit offsets follow from the packed
//   struct field order, MSB first).
package mem_stage_lsu_pkg;

  localparam int ES_TO_MS_BUS_WD = 110;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_DS_FWD_WD = 39;

  typedef enum logic [2:0] {
    LOAD_B   = 3'b000,
    LOAD_H   = 3'b001,
    LOAD_W   = 3'b010,
    LOAD_LWL = 3'b011,
    LOAD_LWR = 3'b100
  } load_op_e;

  // [109:78] rt_value, [77] mem_req, [76] res_from_mem, [75] load_sign,
  // [74:72] load_op, [71:70] addr_lo, [69] gr_we, [68:64] dest,
  // [63:32] alu_result, [31:0] pc
  typedef struct packed {
    logic [31:0] rt_value;
    logic        mem_req;
    logic        res_from_mem;
    logic        load_sign;
    logic [2:0]  load_op;
    logic [1:0]  addr_lo;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  // [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc
  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_t;

  // [38] fwd_valid, [37] fwd_blocked, [36:32] dest, [31:0] final_result
  typedef struct packed {
    logic        fwd_valid;
    logic        fwd_blocked;
    logic [4:0]  dest;
    logic [31:0] final_result;
  } ms_to_ds_fwd_t;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// load_align
//   Combinational load data extraction: byte/half select with sign or zero
//   extension, word pass-through, and (when MS_UNALIGNED_LOAD_EN is defined)
//   LWL/LWR merging with the old register value. Without the macro, LWL/LWR
//   behave as word loads and rt_value is ignored.
// Ports:
//   load_op    in  3   load kind (see load_op_e)
//   load_sign  in  1   sign-extend byte/half
//   addr_lo    in  2   byte offset within the word
//   rdata      in  32  read data word
//   rt_value   in  32  old destination value, used by LWL/LWR
//   load_value out 32  value to write back
module load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic        load_sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_value,
  output logic [31:0] load_value
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata >> {addr_lo, 3'b000};

`ifndef MS_UNALIGNED_LOAD_EN
  logic w_unused_rt;
  assign w_unused_rt = ^rt_value;
`endif

  always_comb begin
    load_value = rdata;
    case (load_op)
      LOAD_B: load_value = {{24{load_sign & w_shifted[7]}}, w_shifted[7:0]};
      LOAD_H: load_value = {{16{load_sign & w_shifted[15]}}, w_shifted[15:0]};
`ifdef MS_UNALIGNED_LOAD_EN
      LOAD_LWL: begin
        case (addr_lo)
          2'd0:    load_value = {rdata[7:0],  rt_value[23:0]};
          2'd1:    load_value = {rdata[15:0], rt_value[15:0]};
          2'd2:    load_value = {rdata[23:0], rt_value[7:0]};
          default: load_value = rdata;
        endcase
      end
      LOAD_LWR: begin
        case (addr_lo)
          2'd0:    load_value = rdata;
          2'd1:    load_value = {rt_value[31:24], rdata[31:8]};
          2'd2:    load_value = {rt_value[31:16], rdata[31:16]};
          default: load_value = {rt_value[31:8],  rdata[31:24]};
        endcase
      end
`endif
      default: load_value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Memory stage of the in-order pipeline. Holds one instruction, waits for
//   the data-SRAM read response of an issued load, buffers that response if
//   writeback is stalled, and produces the writeback and forwarding buses.
//   Optional feature: MS_UNALIGNED_LOAD_EN enables LWL/LWR merging (inside
//   load_align).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ws_allowin            in   writeback can accept this cycle
//   ms_allowin            out  this stage can accept from execute
//   es_to_ms_valid/_bus   in   instruction from execute (110 bits)
//   ms_to_ws_valid/_bus   out  instruction to writeback (70 bits)
//   ms_to_ds_fwd_bus      out  forwarding / load-use stall info (39 bits)
//   data_sram_data_ok     in   read response strobe
//   data_sram_rdata       in   read response data
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_FWD_WD-1:0] ms_to_ds_fwd_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  logic          r_ms_valid;
  es_to_ms_t     r_bus;
  logic [31:0]   r_rdata_buf;
  logic          r_rdata_buf_valid;

  logic          w_ms_ready_go;
  logic          w_leave;
  logic          w_capture;
  logic [31:0]   w_rdata;
  logic [31:0]   w_load_value;
  logic [31:0]   w_final_result;
  ms_to_ws_t     w_ws_bus;
  ms_to_ds_fwd_t w_fwd_bus;

  assign w_ms_ready_go  = !r_bus.mem_req || data_sram_data_ok || r_rdata_buf_valid;
  assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
  assign w_leave        = ms_to_ws_valid && ws_allowin;

  // Only the first response is kept; a repeated strobe while the buffer is
  // full must not overwrite the data already presented to writeback.
  assign w_capture = r_ms_valid && r_bus.mem_req && data_sram_data_ok
                     && !ws_allowin && !r_rdata_buf_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ms_valid        <= 1'b0;
      r_rdata_buf_valid <= 1'b0;
    end else begin
      if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end
      if (w_leave) begin
        r_rdata_buf_valid <= 1'b0;
      end else if (w_capture) begin
        r_rdata_buf_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      r_bus <= es_to_ms_bus;
    end
    if (w_capture) begin
      r_rdata_buf <= data_sram_rdata;
    end
  end

  assign w_rdata = r_rdata_buf_valid ? r_rdata_buf : data_sram_rdata;

  load_align u_load_align (
    .load_op    (r_bus.load_op),
    .load_sign  (r_bus.load_sign),
    .addr_lo    (r_bus.addr_lo),
    .rdata      (w_rdata),
    .rt_value   (r_bus.rt_value),
    .load_value (w_load_value)
  );

  assign w_final_result = r_bus.res_from_mem ? w_load_value : r_bus.alu_result;

  always_comb begin
    w_ws_bus.gr_we        = r_bus.gr_we;
    w_ws_bus.dest         = r_bus.dest;
    w_ws_bus.final_result = w_final_result;
    w_ws_bus.pc           = r_bus.pc;

    w_fwd_bus.fwd_valid    = r_ms_valid && r_bus.gr_we;
    w_fwd_bus.fwd_blocked  = r_bus.res_from_mem && !w_ms_ready_go;
    w_fwd_bus.dest         = r_bus.dest;
    w_fwd_bus.final_result = w_final_result;
  end

  assign ms_to_ws_bus     = w_ws_bus;
  assign ms_to_ds_fwd_bus = w_fwd_bus;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [109:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [69:0]  ms_to_ws_bus;
  logic [38:0]  ms_to_ds_fwd_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Transaction-level model: the instruction held in the stage and, if a
  // response had to be parked, the parked data.
  bit          m_valid = 0;
  bit          m_have  = 0;
  es_to_ms_t   m_ins   = '0;
  logic [31:0] m_data  = '0;

  mem_stage_lsu dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_fwd_bus  (ms_to_ds_fwd_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input es_to_ms_t i, input logic [31:0] d);
    int          sh;
    logic [31:0] v;
    sh = 8 * int'(i.addr_lo);
    v  = d;
    case (i.load_op)
      3'd0: begin
        v = (d >> sh) & 32'h0000_00FF;
        if (i.load_sign && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd1: begin
        v = (d >> sh) & 32'h0000_FFFF;
        if (i.load_sign && v[15]) v = v | 32'hFFFF_0000;
      end
`ifdef MS_UNALIGNED_LOAD_EN
      3'd3: v = (d << (24 - sh)) | (i.rt_value & ((32'd1 << (24 - sh)) - 32'd1));
      3'd4: v = (d >> sh) | (i.rt_value & ~(32'hFFFF_FFFF >> sh));
`endif
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic es_to_ms_t mk(input bit req, input bit res, input bit sgn,
                                   input logic [2:0] op, input logic [1:0] alo,
                                   input logic [31:0] rt, input logic [31:0] alu,
                                   input logic [31:0] pc, input logic [4:0] dest,
                                   input bit we);
    es_to_ms_t b;
    b.rt_value     = rt;
    b.mem_req      = req;
    b.res_from_mem = res;
    b.load_sign    = sgn;
    b.load_op      = op;
    b.addr_lo      = alo;
    b.gr_we        = we;
    b.dest         = dest;
    b.alu_result   = alu;
    b.pc           = pc;
    return b;
  endfunction

  // Per-cycle compare against the model, then advance the model across the
  // coming rising edge using this cycle's inputs.
  always @(negedge clk) begin
    bit          rdy, outv, allow;
    logic [31:0] d, res;
    #2;
    if (chk_en) begin
      rdy   = !m_ins.mem_req || data_sram_data_ok || m_have;
      outv  = m_valid && rdy;
      allow = !m_valid || (rdy && ws_allowin);
      d     = m_have ? m_data : data_sram_rdata;
      res   = m_ins.res_from_mem ? ref_load(m_ins, d) : m_ins.alu_result;

      chk("ms_to_ws_valid", ms_to_ws_valid, outv);
      chk("ms_allowin", ms_allowin, allow);
      chk("fwd_valid", ms_to_ds_fwd_bus[38], m_valid && m_ins.gr_we);
      if (m_valid) begin
        chk("fwd_blocked", ms_to_ds_fwd_bus[37], m_ins.res_from_mem && !rdy);
        chk("fwd_dest", ms_to_ds_fwd_bus[36:32], m_ins.dest);
        chk("fwd_result", ms_to_ds_fwd_bus[31:0], res);
      end
      if (outv) begin
        chk("ms_to_ws_bus", ms_to_ws_bus, {m_ins.gr_we, m_ins.dest, res, m_ins.pc});
      end

      if (reset) begin
        m_valid = 0;
        m_have  = 0;
      end else if (allow) begin
        m_valid = es_to_ms_valid;
        m_have  = 0;
        if (es_to_ms_valid) m_ins = es_to_ms_bus;
      end else if (m_valid && m_ins.mem_req && data_sram_data_ok && !m_have && !ws_allowin) begin
        m_have = 1;
        m_data = data_sram_rdata;
      end
    end
  end

  task automatic step(input bit rst, input bit ev, input es_to_ms_t b, input bit ws,
                      input bit dok, input logic [31:0] rd);
    @(negedge clk);
    reset             = rst;
    es_to_ms_valid    = ev;
    es_to_ms_bus      = b;
    ws_allowin        = ws;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
  endtask

  initial begin
    es_to_ms_t idle, b;
    bit        outst, rst, ev, ws, dok;
    int        kind;
    logic [2:0] op;
    logic [1:0] alo;

    idle              = '0;
    reset             = 1;
    es_to_ms_valid    = 0;
    es_to_ms_bus      = '0;
    ws_allowin        = 1;
    data_sram_data_ok = 0;
    data_sram_rdata   = '0;

    repeat (2) @(negedge clk);
    chk_en = 1;
    #3;
    chk("rst_ms_to_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_ms_allowin", ms_allowin, 1'b1);
    chk("rst_fwd_valid", ms_to_ds_fwd_bus[38], 1'b0);

    // ALU result, one-cycle latency
    step(0, 1, mk(0, 0, 0, 3'd0, 2'd0, 32'h0, 32'h0000_1234, 32'h0000_0100, 5'd5, 1), 1, 0, 32'h0);
    step(0, 0, idle, 1, 0, 32'h0);
    #3;
    chk("alu_valid", ms_to_ws_valid, 1'b1);
    chk("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h0000_1234, 32'h0000_0100});

    // LB, addr_lo=2, response three cycles late
    step(0, 1, mk(1, 1, 1, 3'd0, 2'd2, 32'h0, 32'h0, 32'h0000_0104, 5'd7, 1), 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, idle, 1, 0, 32'h5555_5555);
      #3;
      chk("lb_wait_blocked", ms_to_ds_fwd_bus[37], 1'b1);
      chk("lb_wait_valid", ms_to_ws_valid, 1'b0);
    end
    step(0, 0, idle, 1, 1, 32'h8899_AABB);
    #3;
    chk("lb_valid", ms_to_ws_valid, 1'b1);
    chk("lb_result", ms_to_ws_bus[63:32], 32'hFFFF_FF99);
    chk("lb_unblocked", ms_to_ds_fwd_bus[37], 1'b0);

    // LHU, addr_lo=2
    step(0, 1, mk(1, 1, 0, 3'd1, 2'd2, 32'h0, 32'h0, 32'h0000_0108, 5'd8, 1), 1, 0, 32'h0);
    step(0, 0, idle, 1, 1, 32'h8899_AABB);
    #3;
    chk("lhu_result", ms_to_ws_bus[63:32], 32'h0000_8899);

    // LW under backpressure, later junk strobes must not disturb the result
    step(0, 1, mk(1, 1, 0, 3'd2, 2'd0, 32'h0, 32'h0, 32'h0000_010C, 5'd9, 1), 1, 0, 32'h0);
    step(0, 0, idle, 0, 1, 32'hCAFE_F00D);
    #3;
    chk("bp_valid", ms_to_ws_valid, 1'b1);
    chk("bp_result0", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    chk("bp_allowin", ms_allowin, 1'b0);
    step(0, 0, idle, 0, 1, 32'hDEAD_BEEF);
    #3;
    chk("bp_result1", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    step(0, 0, idle, 0, 0, 32'h1234_5678);
    #3;
    chk("bp_result2", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    step(0, 0, idle, 1, 1, 32'h0BAD_0BAD);
    #3;
    chk("bp_result3", ms_to_ws_bus[63:32], 32'hCAFE_F00D);
    chk("bp_leave_valid", ms_to_ws_valid, 1'b1);
    step(0, 0, idle, 1, 0, 32'h0);
    #3;
    chk("bp_after_valid", ms_to_ws_valid, 1'b0);

    // LWL / LWR
    step(0, 1, mk(1, 1, 0, 3'd3, 2'd1, 32'hAABB_CCDD, 32'h0, 32'h0000_0110, 5'd10, 1), 1, 0, 32'h0);
    step(0, 1, mk(1, 1, 0, 3'd4, 2'd2, 32'hAABB_CCDD, 32'h0, 32'h0000_0114, 5'd11, 1), 1, 1, 32'h1122_3344);
    #3;
`ifdef MS_UNALIGNED_LOAD_EN
    chk("lwl_result", ms_to_ws_bus[63:32], 32'h3344_CCDD);
`else
    chk("lwl_result", ms_to_ws_bus[63:32], 32'h1122_3344);
`endif
    step(0, 0, idle, 1, 1, 32'h1122_3344);
    #3;
`ifdef MS_UNALIGNED_LOAD_EN
    chk("lwr_result", ms_to_ws_bus[63:32], 32'hAABB_1122);
`else
    chk("lwr_result", ms_to_ws_bus[63:32], 32'h1122_3344);
`endif

    // Reset while a load is outstanding, then a stray strobe
    step(0, 1, mk(1, 1, 0, 3'd2, 2'd0, 32'h0, 32'h0, 32'h0000_0118, 5'd12, 1), 1, 0, 32'h0);
    step(1, 0, idle, 1, 0, 32'h0);
    step(0, 0, idle, 1, 1, 32'hFEED_FACE);
    #3;
    chk("rstld_valid", ms_to_ws_valid, 1'b0);
    chk("rstld_fwd_valid", ms_to_ds_fwd_bus[38], 1'b0);
    chk("rstld_allowin", ms_allowin, 1'b1);
    step(0, 0, idle, 1, 0, 32'h0);
    #3;
    chk("rstld_valid_after", ms_to_ws_valid, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      outst = m_valid && m_ins.mem_req && !m_have;
      rst   = ($urandom_range(0, 199) == 0);
      ev    = ($urandom_range(0, 2) != 0);
      ws    = ($urandom_range(0, 3) != 0);
      dok   = outst ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      kind  = $urandom_range(0, 2);
      op    = 3'($urandom_range(0, 4));
      alo   = 2'($urandom_range(0, 3));
      if (op == 3'd1) alo[0] = 1'b0;
      b = mk(kind != 0, kind == 2, 1'($urandom_range(0, 1)), op, alo, $urandom, $urandom,
             $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      step(rst, ev, b, ws, dok, $urandom);
      #3;
    end

    step(0, 0, idle, 1, 0, 32'h0);
    step(0, 0, idle, 1, 0, 32'h0);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
